// File: rtl/dbus_uncached_bridge.sv
// Uncached DBus responder: forwards each core request as one single-beat memory access
// and returns responses in order. Optional store early-ack via `DBUS_WR_EARLY_ACK_EN.
module dbus_uncached_bridge #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // core data bus
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [19:0] data_tag,
  input  logic [7:0]  data_index,
  input  logic [3:0]  data_offset,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        err_resp
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [OUTSTANDING-1:0] acked_q, acked_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       pend_cnt_q, pend_cnt_d;
  logic                   data_ok_q, data_ok_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;
  logic resp_c;
  logic early_c;

  assign full_c  = (pend_cnt_q == CNT_W'(OUTSTANDING));
  assign empty_c = (pend_cnt_q == '0);

  // Address phase is a straight combinational pass-through, gated only by full.
  assign mem_req      = data_req & ~full_c;
  assign data_addr_ok = mem_req & mem_gnt;
  assign mem_wr       = data_wr;
  assign mem_size     = data_size;
  assign mem_addr     = {data_tag, data_index, data_offset};
  assign mem_wstrb    = data_wstrb;
  assign mem_wdata    = data_wdata;

  assign push_c = data_addr_ok;
  // A response with nothing pending is an error, never a pop (covers zero-latency grant+rvalid).
  assign pop_c  = mem_rvalid & ~empty_c;
  assign resp_c = pop_c & ~acked_q[rd_ptr_q];

`ifdef DBUS_WR_EARLY_ACK_EN
  logic [CNT_W-1:0] unacked_q, unacked_d;

  // Early-ack only when nothing un-acked is ahead and no normal response owns this cycle.
  assign early_c = push_c & data_wr & (unacked_q == '0) & ~resp_c;

  always_comb begin
    unacked_d = unacked_q + CNT_W'(push_c & ~early_c) - CNT_W'(resp_c);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      unacked_q <= '0;
    end else begin
      unacked_q <= unacked_d;
    end
  end
`else
  assign early_c = 1'b0;
`endif

  // Tracking FIFO, pointers and response register next-state.
  always_comb begin
    acked_d    = acked_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_cnt_d = pend_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    data_ok_d  = resp_c | early_c;
    rdata_d    = rdata_q;
    err_d      = err_q | (mem_rvalid & empty_c);

    if (push_c) begin
      acked_d[wr_ptr_q] = early_c;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (resp_c) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acked_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_cnt_q <= '0;
      data_ok_q  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      acked_q    <= acked_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_cnt_q <= pend_cnt_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;
  assign err_resp     = err_q;

endmodule
